vga_sync_gen: RTL and testbench

//  Generates 640x480@60Hz VGA raster timing from the 100 MHz board clock.

---
 rtl/vga_sync_gen.sv | 98 +++++++++
 tb/tb_vga_sync_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y raster counters, and
// registered sync/blanking outputs aligned with the registered coordinates.
`timescale 1ns/1ps
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    // CLK_DIV >= 2 keeps DIV_W >= 1 and the first p_tick after reset later than the first edge.
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;

    logic             w_p_tick;
    logic             w_x_last;
    logic             w_y_last;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;

    assign w_p_tick = (r_div == DIV_LAST);
    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            if (w_x_last) begin
                w_x_next = '0;
                w_y_next = w_y_last ? '0 : r_y + 10'd1;
            end else begin
                w_x_next = r_x + 10'd1;
            end
        end
    end

    // Sync/blank decode the next coordinates so they land together with r_x/r_y.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else begin
            r_div      <= w_p_tick ? '0 : r_div + 1'b1;
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_hsync    <= !((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
            r_vsync    <= !((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
            r_video_on <= (w_x_next < X_VIS) && (w_y_next < Y_VIS);
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign p_tick     = w_p_tick;
    assign line_tick  = w_p_tick & w_x_last;
    assign frame_tick = w_p_tick & w_x_last & w_y_last;
    assign pixel_x    = r_x;
    assign pixel_y    = r_y;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance checked cycle by cycle against a
// reference model, plus a reduced-timing instance used for whole-frame scenarios.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    // Reduced timing: H_TOTAL = 17, V_TOTAL = 13, CLK_DIV = 3.
    localparam int S_FRAME = 17 * 13 * 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       hsync, vsync, video_on, p_tick, line_tick, frame_tick;
    logic [9:0] pixel_x, pixel_y;
    logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_line_tick, s_frame_tick;
    logic [9:0] s_pixel_x, s_pixel_y;

    vga_sync_gen dut (
        .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .p_tick(p_tick), .line_tick(line_tick),
        .frame_tick(frame_tick), .pixel_x(pixel_x), .pixel_y(pixel_y)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .clock(clock), .reset(reset), .hsync(s_hsync), .vsync(s_vsync),
        .video_on(s_video_on), .p_tick(s_p_tick), .line_tick(s_line_tick),
        .frame_tick(s_frame_tick), .pixel_x(s_pixel_x), .pixel_y(s_pixel_y)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int sb_prints = 0;
    bit sb_en = 1'b0;
    logic [25:0] exp_q[$];

    // Reference model of the full-size timing: 800 x 525, 4 clocks per pixel.
    int   m_div = 0, m_x = 0, m_y = 0;
    logic m_hs = 1'b1, m_vs = 1'b1, m_vo = 1'b0;

    function automatic logic [25:0] model_vec();
        logic pt, lt, ft;
        pt = (m_div == 3);
        lt = pt && (m_x == 799);
        ft = lt && (m_y == 524);
        return {m_hs, m_vs, m_vo, pt, lt, ft, 10'(m_x), 10'(m_y)};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_div = 0; m_x = 0; m_y = 0;
            m_hs = 1'b1; m_vs = 1'b1; m_vo = 1'b0;
            exp_q.delete();
        end else begin
            if (m_div == 3) begin
                m_div = 0;
                if (m_x == 799) begin
                    m_x = 0;
                    m_y = (m_y == 524) ? 0 : m_y + 1;
                end else begin
                    m_x = m_x + 1;
                end
            end else begin
                m_div = m_div + 1;
            end
            m_hs = !(m_x >= 656 && m_x <= 751);
            m_vs = !(m_y >= 490 && m_y <= 491);
            m_vo = (m_x < 640) && (m_y < 480);
        end
        if (sb_en) exp_q.push_back(model_vec());
    end

    always @(negedge clock) begin
        logic [25:0] exp_v, act_v;
        if (sb_en) begin
            act_v = {hsync, vsync, video_on, p_tick, line_tick, frame_tick, pixel_x, pixel_y};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t got %h", $time, act_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    n_fail++;
                    if (sb_prints < 10)
                        $display("FAIL scoreboard t=%0t got {hs,vs,vo,pt,lt,ft,x,y}=%b %b %b %b %b %b %0d %0d want %b %b %b %b %b %b %0d %0d",
                                 $time, act_v[25], act_v[24], act_v[23], act_v[22], act_v[21], act_v[20],
                                 act_v[19:10], act_v[9:0], exp_v[25], exp_v[24], exp_v[23], exp_v[22],
                                 exp_v[21], exp_v[20], exp_v[19:10], exp_v[9:0]);
                    sb_prints++;
                end
            end
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        n_checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 0,0", pixel_x, pixel_y); end
        n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hsync, vsync); end
        n_checks++; if (video_on !== 1'b0) begin n_fail++; $display("FAIL reset_video_on: got %b want 0", video_on); end
        n_checks++; if ({p_tick, line_tick, frame_tick} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {p_tick, line_tick, frame_tick}); end
        n_checks++; if ({s_hsync, s_vsync, s_video_on, s_p_tick, s_pixel_x, s_pixel_y} !== {1'b1, 1'b1, 1'b0, 1'b0, 20'd0}) begin n_fail++; $display("FAIL reset_small: got hs=%b vs=%b vo=%b pt=%b x=%0d y=%0d want 1 1 0 0 0 0", s_hsync, s_vsync, s_video_on, s_p_tick, s_pixel_x, s_pixel_y); end
        #1 reset = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (video_on !== 1'b1 || p_tick !== 1'b0) begin n_fail++; $display("FAIL release_edge1: got vo=%b pt=%b want 1 0", video_on, p_tick); end
        @(posedge clock); #1;
        n_checks++; if (p_tick !== 1'b0) begin n_fail++; $display("FAIL release_edge2: got pt=%b want 0", p_tick); end
        @(posedge clock); #1;
        n_checks++; if (p_tick !== 1'b1 || pixel_x !== 10'd0) begin n_fail++; $display("FAIL release_edge3: got pt=%b x=%0d want 1 0", p_tick, pixel_x); end
    endtask

    task automatic test_free_run();
        int pt_cnt = 0, last_pt = -1, bad_gap = 0, bad_step = 0;
        logic [9:0] prev_x = 10'd0;
        logic prev_pt = 1'b0;
        do_reset(3);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (p_tick === 1'b1) begin
                if ((last_pt < 0 && k != 3) || (last_pt >= 0 && k - last_pt != 4)) bad_gap++;
                last_pt = k;
                pt_cnt++;
            end
            if (pixel_x !== prev_x) begin
                if (!prev_pt || pixel_x !== prev_x + 10'd1) bad_step++;
            end else if (prev_pt) begin
                bad_step++;
            end
            prev_x = pixel_x;
            prev_pt = p_tick;
        end
        n_checks++; if (pt_cnt != 10) begin n_fail++; $display("FAIL free_run_ptick_count: got %0d want 10", pt_cnt); end
        n_checks++; if (bad_gap != 0) begin n_fail++; $display("FAIL free_run_ptick_period: got %0d bad gaps want 0", bad_gap); end
        n_checks++; if (bad_step != 0) begin n_fail++; $display("FAIL free_run_x_step: got %0d bad steps want 0", bad_step); end
        n_checks++; if (pixel_x !== 10'd10) begin n_fail++; $display("FAIL free_run_x_final: got %0d want 10", pixel_x); end
    endtask

    task automatic test_line();
        int hs_cnt = 0, hs_min = 1023, hs_max = -1, vo_cnt = 0, vo_max = -1, lt_cnt = 0, lt_x = -1;
        do_reset(2);
        for (int k = 1; k <= 3200; k++) begin
            @(posedge clock); #1;
            if (p_tick === 1'b1) begin
                if (hsync === 1'b0) begin
                    hs_cnt++;
                    if (int'(pixel_x) < hs_min) hs_min = int'(pixel_x);
                    if (int'(pixel_x) > hs_max) hs_max = int'(pixel_x);
                end
                if (video_on === 1'b1) begin
                    vo_cnt++;
                    if (int'(pixel_x) > vo_max) vo_max = int'(pixel_x);
                end
                if (line_tick === 1'b1) begin
                    lt_cnt++;
                    lt_x = int'(pixel_x);
                end
            end
        end
        n_checks++; if (hs_cnt != 96) begin n_fail++; $display("FAIL line_hsync_width: got %0d want 96", hs_cnt); end
        n_checks++; if (hs_min != 656 || hs_max != 751) begin n_fail++; $display("FAIL line_hsync_range: got %0d..%0d want 656..751", hs_min, hs_max); end
        n_checks++; if (vo_cnt != 640 || vo_max != 639) begin n_fail++; $display("FAIL line_video_on: got count %0d max %0d want 640 639", vo_cnt, vo_max); end
        n_checks++; if (lt_cnt != 1 || lt_x != 799) begin n_fail++; $display("FAIL line_tick: got count %0d at x=%0d want 1 at 799", lt_cnt, lt_x); end
        n_checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd1) begin n_fail++; $display("FAIL line_wrap: got %0d,%0d want 0,1", pixel_x, pixel_y); end
    endtask

    task automatic test_frame();
        int vs_cnt = 0, vs_min = 1023, vs_max = -1, hs_cnt = 0, vo_cnt = 0, lt_cnt = 0, ft_cnt = 0, ft_x = -1, ft_y = -1;
        do_reset(2);
        for (int k = 1; k <= S_FRAME; k++) begin
            @(posedge clock); #1;
            if (s_p_tick === 1'b1) begin
                if (s_vsync === 1'b0) begin
                    vs_cnt++;
                    if (int'(s_pixel_y) < vs_min) vs_min = int'(s_pixel_y);
                    if (int'(s_pixel_y) > vs_max) vs_max = int'(s_pixel_y);
                end
                if (s_hsync === 1'b0) hs_cnt++;
                if (s_video_on === 1'b1) vo_cnt++;
                if (s_line_tick === 1'b1) lt_cnt++;
                if (s_frame_tick === 1'b1) begin
                    ft_cnt++;
                    ft_x = int'(s_pixel_x);
                    ft_y = int'(s_pixel_y);
                end
            end
        end
        n_checks++; if (vs_cnt != 34 || vs_min != 8 || vs_max != 9) begin n_fail++; $display("FAIL frame_vsync: got %0d at y=%0d..%0d want 34 at 8..9", vs_cnt, vs_min, vs_max); end
        n_checks++; if (hs_cnt != 39) begin n_fail++; $display("FAIL frame_hsync_count: got %0d want 39", hs_cnt); end
        n_checks++; if (vo_cnt != 60) begin n_fail++; $display("FAIL frame_video_on: got %0d want 60", vo_cnt); end
        n_checks++; if (lt_cnt != 13) begin n_fail++; $display("FAIL frame_line_ticks: got %0d want 13", lt_cnt); end
        n_checks++; if (ft_cnt != 1 || ft_x != 16 || ft_y != 12) begin n_fail++; $display("FAIL frame_tick: got count %0d at (%0d,%0d) want 1 at (16,12)", ft_cnt, ft_x, ft_y); end
        n_checks++; if (s_pixel_x !== 10'd0 || s_pixel_y !== 10'd0) begin n_fail++; $display("FAIL frame_wrap: got %0d,%0d want 0,0", s_pixel_x, s_pixel_y); end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        repeat (6001) @(posedge clock);
        #1;
        n_checks++; if (pixel_x !== 10'd700 || pixel_y !== 10'd1 || hsync !== 1'b0) begin n_fail++; $display("FAIL mid_setup: got x=%0d y=%0d hs=%b want 700 1 0", pixel_x, pixel_y, hsync); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 || video_on !== 1'b0) begin n_fail++; $display("FAIL mid_async_reset: got x=%0d y=%0d hs=%b vs=%b vo=%b want 0 0 1 1 0", pixel_x, pixel_y, hsync, vsync, video_on); end
        n_checks++; if ({p_tick, line_tick, frame_tick, s_p_tick} !== 4'b0000 || s_pixel_x !== 10'd0 || s_pixel_y !== 10'd0) begin n_fail++; $display("FAIL mid_async_strobes: got pt=%b lt=%b ft=%b spt=%b sx=%0d sy=%0d want 0 0 0 0 0 0", p_tick, line_tick, frame_tick, s_p_tick, s_pixel_x, s_pixel_y); end
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (video_on !== 1'b1 || p_tick !== 1'b0) begin n_fail++; $display("FAIL mid_restart_edge1: got vo=%b pt=%b want 1 0", video_on, p_tick); end
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (p_tick !== 1'b1 || pixel_x !== 10'd0 || pixel_y !== 10'd0) begin n_fail++; $display("FAIL mid_restart_ptick: got pt=%b x=%0d y=%0d want 1 0 0", p_tick, pixel_x, pixel_y); end
    endtask

    task automatic test_two_frames();
        int t[3] = '{default: 0};
        int cnt = 0, xbad = 0;
        do_reset(2);
        for (int k = 1; k <= 4 * S_FRAME && cnt < 3; k++) begin
            @(posedge clock); #1;
            if ($isunknown({s_hsync, s_vsync, s_video_on, s_p_tick, s_line_tick, s_frame_tick, s_pixel_x, s_pixel_y})) xbad++;
            if (s_frame_tick === 1'b1) begin
                t[cnt] = k;
                cnt++;
            end
        end
        n_checks++; if (cnt != 3) begin n_fail++; $display("FAIL two_frames_timeout: got %0d frame ticks want 3", cnt); end
        n_checks++; if (t[0] != S_FRAME - 1) begin n_fail++; $display("FAIL two_frames_first: got clock %0d want %0d", t[0], S_FRAME - 1); end
        n_checks++; if (t[1] - t[0] != S_FRAME || t[2] - t[1] != S_FRAME) begin n_fail++; $display("FAIL two_frames_spacing: got %0d %0d want %0d", t[1] - t[0], t[2] - t[1], S_FRAME); end
        n_checks++; if (xbad != 0) begin n_fail++; $display("FAIL two_frames_no_x: got %0d unknown samples want 0", xbad); end
    endtask

    initial begin
        #1;
        exp_q.delete();
        exp_q.push_back(model_vec());
        sb_en = 1'b1;
        test_reset();
        test_free_run();
        test_line();
        test_frame();
        test_reset_mid();
        test_two_frames();
        @(negedge clock);
        sb_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
